// File: rtl/mem_ctrl_ws.sv
// mem_ctrl_ws: wait-state-aware MEM-stage bus controller with lane steering, load extension and timeout detection
module mem_ctrl_ws #(
    parameter int DATA_W  = 32,
    parameter int BE_W    = DATA_W / 8,
    parameter int OFFS_W  = $clog2(BE_W),
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_en,
    input  logic [3:0]               ex_mem_op,
    input  logic [DATA_W-1:0]        ex_mem_wr_data,
    input  logic [DATA_W-1:0]        ex_out,
    input  logic [DATA_W-1:0]        rd_data,
    input  logic                     rdy_,
    output logic [DATA_W-OFFS_W-1:0] addr,
    output logic                     as_,
    output logic                     rw,
    output logic [BE_W-1:0]          be_,
    output logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        out,
    output logic                     stall,
    output logic                     miss_align,
    output logic                     bus_err
);
    localparam logic [3:0] LDW = 4'd1, STW = 4'd2, LDH = 4'd3, LDHU = 4'd4,
                           LDB = 4'd5, LDBU = 4'd6, STH = 4'd7, STB = 4'd8;
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, next_state;
    logic [7:0] wcnt, next_wcnt;
    logic [OFFS_W-1:0] offs;
    logic [DATA_W-1:0] ld_sh, ld_data;
    logic is_w, is_h, is_b, is_ld, is_mem, aligned, acc, done, tmo;
    assign offs    = ex_out[OFFS_W-1:0];
    assign addr    = ex_out[DATA_W-1:OFFS_W];
    assign is_w    = ex_mem_op == LDW || ex_mem_op == STW;
    assign is_h    = ex_mem_op == LDH || ex_mem_op == LDHU || ex_mem_op == STH;
    assign is_b    = ex_mem_op == LDB || ex_mem_op == LDBU || ex_mem_op == STB;
    assign is_ld   = ex_mem_op inside {LDW, LDH, LDHU, LDB, LDBU};
    assign is_mem  = is_w || is_h || is_b;
    assign aligned = is_b || (is_h && !offs[0]) || (is_w && offs == '0);
    // acc covers reset and flush: a dropped ex_en or reset abandons the access
    assign acc     = reset && ex_en && is_mem && aligned;
    assign done    = acc && !rdy_;
    assign tmo     = acc && state == S_WAIT && rdy_ && wcnt == 8'(TIMEOUT);
    assign ld_sh   = rd_data >> {offs, 3'b000};
    assign ld_data = ex_mem_op == LDW  ? ld_sh :
                     ex_mem_op == LDH  ? DATA_W'($signed(ld_sh[15:0])) :
                     ex_mem_op == LDHU ? DATA_W'(ld_sh[15:0]) :
                     ex_mem_op == LDB  ? DATA_W'($signed(ld_sh[7:0])) :
                                         DATA_W'(ld_sh[7:0]);
    assign wr_data = is_b ? {BE_W{ex_mem_wr_data[7:0]}} :
                     is_h ? {(BE_W / 2){ex_mem_wr_data[15:0]}} : ex_mem_wr_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else begin
            state <= next_state;
            wcnt  <= next_wcnt;
        end
    end

    always_comb begin
        next_state = S_IDLE;
        next_wcnt  = '0;
        if (acc && rdy_ && !tmo) begin
            next_state = S_WAIT;
            next_wcnt  = state == S_IDLE ? 8'd1 : wcnt + 8'd1;
        end
    end

    always_comb begin
        as_        = !(acc && !tmo);
        rw         = as_ || is_ld;
        be_        = as_  ? '1 :
                     is_w ? '0 :
                     is_h ? ~(BE_W'(3) << offs) : ~(BE_W'(1) << offs);
        stall      = acc && rdy_ && !tmo;
        miss_align = reset && ex_en && is_mem && !aligned;
        bus_err    = tmo;
        out        = !(reset && ex_en) ? '0 :
                     !is_mem           ? ex_out :
                     done && is_ld     ? ld_data : '0;
    end
endmodule

// File: tb/tb_mem_ctrl_ws.sv
// tb_mem_ctrl_ws: table vectors plus multi-cycle sequences, checked through an expected-output queue
module tb_mem_ctrl_ws;
    localparam logic [3:0] NOP = 4'd0, LDW = 4'd1, STW = 4'd2, LDH = 4'd3, LDHU = 4'd4,
                           LDB = 4'd5, LDBU = 4'd6, STH = 4'd7, STB = 4'd8;
    logic clk = 0, reset = 0, ex_en = 0, rdy_ = 1;
    logic [3:0] ex_mem_op = '0;
    logic [31:0] ex_mem_wr_data = '0, ex_out = '0, rd_data = '0;
    logic [29:0] addr;
    logic as_, rw, stall, miss_align, bus_err;
    logic [3:0] be_;
    logic [31:0] wr_data, out;
    int checks = 0, failures = 0;

    typedef struct {
        logic e_as, e_rw, e_st, e_ma, e_err, cw;
        logic [3:0] e_be;
        logic [31:0] e_out, e_wd;
        logic [29:0] e_ad;
    } exp_t;
    typedef struct {
        logic r, en, rdy;
        logic [3:0] op;
        logic [31:0] xo, wd, rd;
        exp_t e;
    } vec_t;
    exp_t sb[$];
    vec_t tbl[14];

    mem_ctrl_ws #(.DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .ex_en(ex_en), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out), .rd_data(rd_data), .rdy_(rdy_),
        .addr(addr), .as_(as_), .rw(rw), .be_(be_), .wr_data(wr_data), .out(out),
        .stall(stall), .miss_align(miss_align), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, en, input logic [3:0] op, input logic [31:0] xo, wd, rd,
                                input logic rdy, e_as, e_rw, input logic [3:0] e_be, input logic [31:0] e_out,
                                input logic e_st, e_ma, e_err, cw, input logic [29:0] e_ad, input logic [31:0] e_wd);
        vec_t v;
        v.r = r; v.en = en; v.op = op; v.xo = xo; v.wd = wd; v.rd = rd; v.rdy = rdy;
        v.e.e_as = e_as; v.e.e_rw = e_rw; v.e.e_be = e_be; v.e.e_out = e_out; v.e.e_st = e_st;
        v.e.e_ma = e_ma; v.e.e_err = e_err; v.e.cw = cw; v.e.e_ad = e_ad; v.e.e_wd = e_wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        reset = v.r; ex_en = v.en; ex_mem_op = v.op; ex_out = v.xo;
        ex_mem_wr_data = v.wd; rd_data = v.rd; rdy_ = v.rdy;
        sb.push_back(v.e);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".as_"}, 32'(as_), 32'(e.e_as));
        chk({tag, ".rw"}, 32'(rw), 32'(e.e_rw));
        chk({tag, ".be_"}, 32'(be_), 32'(e.e_be));
        chk({tag, ".out"}, out, e.e_out);
        chk({tag, ".stall"}, 32'(stall), 32'(e.e_st));
        chk({tag, ".miss_align"}, 32'(miss_align), 32'(e.e_ma));
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(e.e_err));
        if (e.cw) begin
            chk({tag, ".addr"}, 32'(addr), 32'(e.e_ad));
            chk({tag, ".wr_data"}, wr_data, e.e_wd);
        end
    endtask

    initial begin
        vec_t wt, cp, to, rs, fl;
        tbl[0]  = mk(1, 1, LDB,  32'h103,  0, 32'h80FF_1234, 0, 0, 1, 4'b0111, 32'hFFFF_FF80, 0, 0, 0, 1, 30'h40, 0);
        tbl[1]  = mk(1, 1, LDBU, 32'h103,  0, 32'h80FF_1234, 0, 0, 1, 4'b0111, 32'h0000_0080, 0, 0, 0, 1, 30'h40, 0);
        tbl[2]  = mk(1, 1, STH,  32'h202, 32'hDEAD_BEEF, 0, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 1, 30'h80, 32'hBEEF_BEEF);
        tbl[3]  = mk(1, 1, LDW,  32'h101,  0, 0, 0, 1, 1, 4'b1111, 0, 0, 1, 0, 1, 30'h40, 0);
        tbl[4]  = mk(1, 1, LDH,  32'h103,  0, 0, 1, 1, 1, 4'b1111, 0, 0, 1, 0, 1, 30'h40, 0);
        tbl[5]  = mk(1, 1, LDH,  32'h102,  0, 32'h8001_0000, 0, 0, 1, 4'b0011, 32'hFFFF_8001, 0, 0, 0, 1, 30'h40, 0);
        tbl[6]  = mk(1, 1, LDHU, 32'h102,  0, 32'h8001_0000, 0, 0, 1, 4'b0011, 32'h0000_8001, 0, 0, 0, 1, 30'h40, 0);
        tbl[7]  = mk(1, 1, NOP,  32'h1234, 0, 0, 0, 1, 1, 4'b1111, 32'h1234, 0, 0, 0, 1, 30'h48D, 0);
        tbl[8]  = mk(1, 0, LDW,  32'h100,  0, 32'h5555_5555, 0, 1, 1, 4'b1111, 0, 0, 0, 0, 1, 30'h40, 0);
        tbl[9]  = mk(1, 1, 4'd9, 32'h55,   0, 0, 0, 1, 1, 4'b1111, 32'h55, 0, 0, 0, 1, 30'h15, 0);
        tbl[10] = mk(1, 1, STB,  32'h101, 32'h0000_00AB, 0, 0, 0, 0, 4'b1101, 0, 0, 0, 0, 1, 30'h40, 32'hABAB_ABAB);
        tbl[11] = mk(1, 1, LDW,  32'h100,  0, 32'hCAFE_BABE, 0, 0, 1, 4'b0000, 32'hCAFE_BABE, 0, 0, 0, 1, 30'h40, 0);
        tbl[12] = mk(1, 1, LDB,  32'h100,  0, 32'h0000_007F, 0, 0, 1, 4'b1110, 32'h0000_007F, 0, 0, 0, 1, 30'h40, 0);
        tbl[13] = mk(1, 1, STW,  32'h104, 32'h0102_0304, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1, 30'h41, 32'h0102_0304);
        wt = mk(1, 1, LDW, 32'h400, 0, 32'h1234_5678, 1, 0, 1, 4'b0000, 0, 1, 0, 0, 1, 30'h100, 0);
        cp = mk(1, 1, LDW, 32'h400, 0, 32'h1234_5678, 0, 0, 1, 4'b0000, 32'h1234_5678, 0, 0, 0, 1, 30'h100, 0);
        to = mk(1, 1, LDW, 32'h400, 0, 32'h1234_5678, 1, 1, 1, 4'b1111, 0, 0, 0, 1, 1, 30'h100, 0);
        rs = mk(0, 1, LDW, 32'h400, 0, 32'h1234_5678, 1, 1, 1, 4'b1111, 0, 0, 0, 0, 0, 0, 0);
        fl = mk(1, 0, LDW, 32'h400, 0, 32'h1234_5678, 1, 1, 1, 4'b1111, 0, 0, 0, 0, 1, 30'h100, 0);

        step("reset_hold", rs);
        step("reset_rdy0", mk(0, 1, LDW, 32'h400, 0, 32'h1234_5678, 0, 1, 1, 4'b1111, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 14; i++) step($sformatf("vec%0d", i), tbl[i]);
        step("misalign_rdy1", mk(1, 1, LDW, 32'h101, 0, 0, 1, 1, 1, 4'b1111, 0, 0, 1, 0, 1, 30'h40, 0));
        step("after_misalign", cp);

        for (int i = 0; i < 3; i++) step($sformatf("wait%0d", i), wt);
        step("wait_done", cp);
        step("b2b", cp);

        for (int i = 0; i < 4; i++) step($sformatf("tmo_stall%0d", i), wt);
        step("tmo_err", to);
        step("tmo_reissue", wt);
        step("tmo_flush", fl);

        for (int i = 0; i < 4; i++) step($sformatf("late_stall%0d", i), wt);
        step("late_done", cp);

        step("rst_w0", wt);
        step("rst_w1", wt);
        step("rst_mid", rs);
        step("rst_new_wait", wt);
        step("rst_new_done", cp);

        step("fl_w0", wt);
        step("fl_w1", wt);
        step("fl_drop", fl);
        step("fl_new_done", cp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
